// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync input conditioner.
// Optional glitch counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
package debounce_pkg;

   // Debounce FSM state encoding
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } db_state_t;

   // Default build-time constants
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DB_COUNT    = 8;

   // Width of the aborted-check counter
   localparam int GLITCH_CNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [GLITCH_CNT_W-1:0] glitch_sat_inc(
      input logic [GLITCH_CNT_W-1:0] v
   );
      logic [GLITCH_CNT_W-1:0] r;
      r = (v == {GLITCH_CNT_W{1'b1}}) ? v : v + {{(GLITCH_CNT_W-1){1'b0}}, 1'b1};
      return r;
   endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Reusable by any input stage; all flops clear on synchronous active-low reset.
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift the raw bit one stage deeper each clock
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   // Synchronizer register chain
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw asynchronous level, producing a clean
// registered level plus one-cycle rise/fall strobes and a busy flag.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_COUNT    = DEF_DB_COUNT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    din,
`ifdef DEBOUNCE_GLITCH_CNT_EN
   output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
   output logic                    dout,
   output logic                    rise,
   output logic                    fall,
   output logic                    busy
);

   // Counter only needs to reach DB_COUNT-1, so it never wraps
   localparam int              CNT_W    = $clog2(DB_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (din),
      .q    (s)
   );

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next-state: qualify a candidate level over DB_COUNT consecutive samples
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s) begin
               state_d = CHECK_HI;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               dout_d  = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s) begin
               state_d = CHECK_LO;
               cnt_d   = CNT_ONE;
            end
         end
         CHECK_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               dout_d  = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: registered level/strobes, busy decoded from state
   always_comb begin
      busy = (state_q == CHECK_HI) || (state_q == CHECK_LO);
      dout = dout_q;
      rise = rise_q;
      fall = fall_q;
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic                    abort;
   logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

   // A check is aborted when the candidate level disappears before acceptance
   always_comb begin
      abort    = ((state_q == CHECK_HI) && !s) || ((state_q == CHECK_LO) && s);
      glitch_d = abort ? glitch_sat_inc(glitch_q) : glitch_q;
   end

   // Saturating aborted-check counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync with a run-length reference model.
// Glitch counter checks are compiled in when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_debounce_sync;

   localparam int SYNC = 2;
   localparam int DB   = 8;
   localparam int LAT  = SYNC + DB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic din = 1'b0;
   logic dout, rise, fall, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
`endif

   int checks = 0;
   int passed = 0;

   debounce_sync #(
      .SYNC_STAGES(SYNC),
      .DB_COUNT   (DB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .glitch_cnt(glitch_cnt),
`endif
      .dout      (dout),
      .rise      (rise),
      .fall      (fall),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference model: din is seen by the qualifier SYNC edges late; a level is
   // accepted after DB consecutive samples that differ from the current output.
   logic [SYNC-1:0] m_pipe = '0;
   logic m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
   int   m_run = 0;
   int   m_glitch = 0;

   always @(posedge clk) begin : model
      logic s;
      int   run_n, g_n;
      logic d_n, r_n, f_n;
      if (!rst_n) begin
         m_pipe   <= '0;
         m_dout   <= 1'b0;
         m_rise   <= 1'b0;
         m_fall   <= 1'b0;
         m_run    <= 0;
         m_glitch <= 0;
      end else begin
         s = m_pipe[SYNC-1];
         run_n = m_run; d_n = m_dout; r_n = 1'b0; f_n = 1'b0; g_n = m_glitch;
         if (s != m_dout) begin
            run_n = run_n + 1;
            if (run_n == DB) begin
               d_n = s; r_n = s; f_n = ~s; run_n = 0;
            end
         end else begin
            if (run_n > 0 && g_n < 255) g_n = g_n + 1;
            run_n = 0;
         end
         m_run    <= run_n;
         m_dout   <= d_n;
         m_rise   <= r_n;
         m_fall   <= f_n;
         m_glitch <= g_n;
         m_pipe   <= {m_pipe[SYNC-2:0], din};
      end
   end

   // Drive inputs, wait for one active edge, settle before sampling
   task automatic drive(input logic d, input logic r);
      din = d;
      rst_n = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0);
         checks++;
         if ({dout, rise, fall, busy} !== 4'b0000)
            $display("FAIL reset_hold cyc=%0d got=%b exp=0000", i, {dout, rise, fall, busy});
         else passed++;
      end
      for (int k = 1; k <= 14; k++) begin
         drive(1'b1, 1'b1);
         checks++;
         if ({dout, rise} !== {k >= LAT, k == LAT})
            $display("FAIL reset_release edge=%0d got dout/rise=%b%b exp=%b%b", k, dout, rise, k >= LAT, k == LAT);
         else passed++;
         exp = {m_dout, m_rise, m_fall, m_run > 0};
         checks++;
         if ({dout, rise, fall, busy} !== exp)
            $display("FAIL reset_model edge=%0d got=%b exp=%b", k, {dout, rise, fall, busy}, exp);
         else passed++;
      end
   endtask

   task automatic test_glitch();
      int busy_cycles = 0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         drive(k <= 5, 1'b1);
         if (busy) busy_cycles++;
         checks++;
         if ({dout, rise, fall} !== 3'b000 || busy !== (m_run > 0))
            $display("FAIL glitch edge=%0d got d/r/f/b=%b exp=000%b", k, {dout, rise, fall, busy}, m_run > 0);
         else passed++;
      end
      checks++;
      if (busy_cycles !== 5) $display("FAIL glitch_busy_len got=%0d exp=5", busy_cycles);
      else passed++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (glitch_cnt !== 8'd1) $display("FAIL glitch_cnt_single got=%0d exp=1", glitch_cnt);
      else passed++;
`endif
   endtask

   task automatic test_clean();
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         drive(1'b1, 1'b1);
         checks++;
         if ({dout, rise, fall} !== {k >= LAT, k == LAT, 1'b0})
            $display("FAIL clean_press edge=%0d got=%b exp=%b", k, {dout, rise, fall}, {k >= LAT, k == LAT, 1'b0});
         else passed++;
      end
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, 1'b1);
         checks++;
         if ({dout, rise, fall} !== {k < LAT, 1'b0, k == LAT})
            $display("FAIL clean_release edge=%0d got=%b exp=%b", k, {dout, rise, fall}, {k < LAT, 1'b0, k == LAT});
         else passed++;
      end
   endtask

   task automatic test_bounce();
      logic [5:0] pat = 6'b010101;
      int rises = 0, rise_edge = -1;
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         drive((k <= 6) ? pat[k-1] : 1'b1, 1'b1);
         if (rise) begin rises++; rise_edge = k; end
         checks++;
         if ({dout, rise, fall, busy} !== {m_dout, m_rise, m_fall, m_run > 0})
            $display("FAIL bounce_model edge=%0d got=%b exp=%b", k, {dout, rise, fall, busy}, {m_dout, m_rise, m_fall, m_run > 0});
         else passed++;
      end
      checks++;
      if (rises !== 1 || rise_edge !== 7 + LAT - 1)
         $display("FAIL bounce_rise got count=%0d edge=%0d exp count=1 edge=%0d", rises, rise_edge, 7 + LAT - 1);
      else passed++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      checks++;
      if (glitch_cnt !== 8'd3) $display("FAIL bounce_glitch_cnt got=%0d exp=3", glitch_cnt);
      else passed++;
`endif
   endtask

   task automatic test_threshold();
      int rises = 0;
      do_reset();
      for (int k = 1; k <= 7 + 12; k++) begin
         drive(k <= 7, 1'b1);
         if (rise) rises++;
         checks++;
         if (dout !== 1'b0) $display("FAIL thresh_short edge=%0d got dout=%b exp=0", k, dout);
         else passed++;
      end
      checks++;
      if (rises !== 0) $display("FAIL thresh_short_rise got=%0d exp=0", rises);
      else passed++;
      for (int k = 1; k <= 8 + 12; k++) begin
         drive(k <= 8, 1'b1);
         if (rise) rises++;
         checks++;
         if ({dout, rise, fall} !== {m_dout, m_rise, m_fall})
            $display("FAIL thresh_full edge=%0d got=%b exp=%b", k, {dout, rise, fall}, {m_dout, m_rise, m_fall});
         else passed++;
      end
      checks++;
      if (rises !== 1) $display("FAIL thresh_full_rise got=%0d exp=1", rises);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int rises = 0;
      do_reset();
      for (int k = 1; k <= 5; k++) drive(1'b1, 1'b1);
      checks++;
      if (busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", busy);
      else passed++;
      drive(1'b1, 1'b0);
      checks++;
      if ({dout, rise, fall, busy} !== 4'b0000)
         $display("FAIL mid_reset got=%b exp=0000", {dout, rise, fall, busy});
      else passed++;
      for (int k = 1; k <= 14; k++) begin
         drive(1'b1, 1'b1);
         if (rise) rises++;
         checks++;
         if ({dout, rise} !== {k >= LAT, k == LAT})
            $display("FAIL mid_release edge=%0d got dout/rise=%b%b exp=%b%b", k, dout, rise, k >= LAT, k == LAT);
         else passed++;
      end
      checks++;
      if (rises !== 1) $display("FAIL mid_rise_count got=%0d exp=1", rises);
      else passed++;
   endtask

   task automatic test_random();
      logic lvl = 1'b0;
      int   left = 0;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if (left == 0) begin
            lvl  = $urandom_range(1, 0);
            left = $urandom_range(12, 1);
         end
         left--;
         drive(lvl, ($urandom_range(149, 0) != 0));
         checks++;
         if ({dout, rise, fall, busy} !== {m_dout, m_rise, m_fall, m_run > 0} || (rise && fall))
            $display("FAIL random_model cyc=%0d got=%b exp=%b", k, {dout, rise, fall, busy}, {m_dout, m_rise, m_fall, m_run > 0});
         else passed++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         checks++;
         if (int'(glitch_cnt) !== m_glitch)
            $display("FAIL random_glitch cyc=%0d got=%0d exp=%0d", k, glitch_cnt, m_glitch);
         else passed++;
`endif
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_glitch();
      test_clean();
      test_bounce();
      test_threshold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
